// File: rtl/ram_port_arbiter.sv
// Shares the F8 data RAM read and write ports between r0 (priority) and r1 (starvation-protected).
// Optional address range checking is enabled by defining RAM_ARB_RANGE_CHECK_EN.
module ram_port_arbiter #(
  parameter int SIZE     = 1024,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        r0_req,
  input  logic [1:0]  r0_we,
  input  logic [15:0] r0_addr,
  input  logic [15:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [15:0] r0_rdata,
  input  logic        r1_req,
  input  logic [1:0]  r1_we,
  input  logic [15:0] r1_addr,
  input  logic [15:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [15:0] r1_rdata,
  output logic [15:0] ram_dread_addr,
  input  logic [15:0] ram_dread_data,
  output logic [15:0] ram_dwrite_addr,
  output logic [15:0] ram_dwrite_data,
  output logic [1:0]  ram_dwrite_en,
  output logic        err
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  if (MAX_WAIT < 1 || SIZE < 2 || SIZE > 'h4000) begin : g_param_check
    $error("ram_port_arbiter: SIZE or MAX_WAIT out of range");
  end

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic              r0_rd, r0_wr, r1_rd, r1_wr;
  logic              rd_clash, wr_clash, r1_turn;
  logic              g0_rd, g0_wr, g1_rd, g1_wr, rd_any;
  logic              r0_bad, r1_bad;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       rd_addr_q;
  logic              ret_valid, ret_owner, ret_zero;

  assign r0_rd    = r0_req & (r0_we == 2'b00);
  assign r0_wr    = r0_req & (r0_we != 2'b00);
  assign r1_rd    = r1_req & (r1_we == 2'b00);
  assign r1_wr    = r1_req & (r1_we != 2'b00);
  assign rd_clash = r0_rd & r1_rd;
  assign wr_clash = r0_wr & r1_wr;
  assign r1_turn  = (wait_cnt >= WAIT_SAT);

  // Each port is arbitrated on its own; a read never blocks a write.
  assign g0_rd  = rst_n & r0_rd & ~(rd_clash & r1_turn);
  assign g1_rd  = rst_n & r1_rd & ~(rd_clash & ~r1_turn);
  assign g0_wr  = rst_n & r0_wr & ~(wr_clash & r1_turn);
  assign g1_wr  = rst_n & r1_wr & ~(wr_clash & ~r1_turn);
  assign rd_any = g0_rd | g1_rd;
  assign r0_gnt = g0_rd | g0_wr;
  assign r1_gnt = g1_rd | g1_wr;

`ifdef RAM_ARB_RANGE_CHECK_EN
  localparam logic [16:0] WIN_LO = 17'('h4000 - SIZE);
  localparam logic [16:0] WIN_HI = 17'h03FFF;

  function automatic logic out_of_range(input logic [15:0] addr, input logic [1:0] we);
    logic [16:0] lo_byte;
    logic [16:0] hi_byte;
    lo_byte = {1'b0, addr};
    hi_byte = lo_byte + 17'd1;
    return (lo_byte < WIN_LO) || (lo_byte > WIN_HI) ||
           (((we == 2'b00) || we[1]) && ((hi_byte < WIN_LO) || (hi_byte > WIN_HI)));
  endfunction

  assign r0_bad = out_of_range(r0_addr, r0_we);
  assign r1_bad = out_of_range(r1_addr, r1_we);
`else
  assign r0_bad = 1'b0;
  assign r1_bad = 1'b0;
`endif

  assign ram_dread_addr = g1_rd ? r1_addr : (g0_rd ? r0_addr : rd_addr_q);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ram_dwrite_addr = r0_addr;
    ram_dwrite_data = r0_wdata;
    ram_dwrite_en   = 2'b00;
    if (g1_wr) begin
      ram_dwrite_addr = r1_addr;
      ram_dwrite_data = r1_wdata;
      ram_dwrite_en   = r1_bad ? 2'b00 : r1_we;
    end else if (g0_wr) begin
      ram_dwrite_en   = r0_bad ? 2'b00 : r0_we;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      rd_addr_q <= '0;
      ret_valid <= 1'b0;
      ret_owner <= 1'b0;
      ret_zero  <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      if (r1_req && !r1_gnt) begin
        if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      ret_valid <= rd_any;
      if (rd_any) begin
        rd_addr_q <= ram_dread_addr;
        ret_owner <= g1_rd;
        ret_zero  <= g1_rd ? r1_bad : r0_bad;
      end

      // RAM data is valid the cycle the tag is; it lands in rdata one edge later.
      if (ret_valid && !ret_owner) r0_rdata <= ret_zero ? 16'h0000 : ram_dread_data;
      if (ret_valid &&  ret_owner) r1_rdata <= ret_zero ? 16'h0000 : ram_dread_data;
    end
  end

  assign r0_rvalid = ret_valid & ~ret_owner;
  assign r1_rvalid = ret_valid &  ret_owner;

`ifdef RAM_ARB_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    err <= 1'b0;
    else if ((r0_gnt & r0_bad) | (r1_gnt & r1_bad)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
